// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-word miss fill.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module icache #(
    parameter int          SETS    = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic        cacheState
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - IW - 2;

    localparam logic IDLE  = 1'b0;
    localparam logic FETCH = 1'b1;

    logic            state;
    logic [31:0]     fetchAddr;
    logic [SETS-1:0] validBits;
    logic [TW-1:0]   tagArr  [SETS];
    logic [31:0]     dataArr [SETS];

    logic [IW-1:0] reqIndex;
    logic [TW-1:0] reqTag;
    logic [IW-1:0] fillIndex;
    logic [TW-1:0] fillTag;
    logic          lookupHit;
    logic          startFetch;
    logic          fillDone;
    logic          unusedOk;

    // Byte offset and the informational reset PC play no part in the lookup.
    assign unusedOk = ^{imemaddr[1:0], PC_INIT};

    assign reqIndex  = imemaddr[IW+1:2];
    assign reqTag    = imemaddr[31:IW+2];
    assign fillIndex = fetchAddr[IW+1:2];
    assign fillTag   = fetchAddr[31:IW+2];

    assign lookupHit  = (state == IDLE) && imemREN && validBits[reqIndex]
                        && (tagArr[reqIndex] == reqTag);
    assign startFetch = (state == IDLE) && imemREN && !lookupHit;
    assign fillDone   = (state == FETCH) && !iwait;

    assign ihit       = lookupHit;
    assign imemload   = lookupHit ? dataArr[reqIndex] : 32'h0;
    assign iREN       = (state == FETCH);
    assign iaddr      = (state == FETCH) ? fetchAddr : 32'h0;
    assign cacheState = state;

    // Handshake: while iREN is high, iaddr is held; a cycle with iREN=1 and
    // iwait=0 transfers iload and ends the fill. Once started, a fill always
    // completes regardless of what the fetch stage does meanwhile.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            fetchAddr <= 32'h0;
            validBits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startFetch) begin
                        state     <= FETCH;
                        fetchAddr <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state                <= IDLE;
                        validBits[fillIndex] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data need no reset: validBits gates every use of them.
    always_ff @(posedge CLK) begin
        if (fillDone) begin
            tagArr[fillIndex]  <= fillTag;
            dataArr[fillIndex] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hitCnt  <= 32'h0;
            missCnt <= 32'h0;
        end else begin
            if (lookupHit && (hitCnt != 32'hFFFF_FFFF))
                hitCnt <= hitCnt + 32'd1;
            if (startFetch && (missCnt != 32'hFFFF_FFFF))
                missCnt <= missCnt + 32'd1;
        end
    end

    assign hit_count  = hitCnt;
    assign miss_count = missCnt;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, warm hit, conflict, redirect,
// reset mid-fill and dropped requests, with counters checked per build.
module tb_icache;
    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        cacheState;

    int nAsserts = 0;
    int nFails   = 0;

`ifdef ICACHE_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif

    icache #(.SETS(16), .PC_INIT(32'h0)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .cacheState(cacheState)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr,
                         input logic wt, input logic [31:0] ld);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_state", {31'h0, cacheState}, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);
        nRST = 1'b1;

        // Cold miss on 0x40, memory stalls 3 cycles (cycles 0..5).
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("cold_c0_ihit", {31'h0, ihit}, 32'h0);
        chk("cold_c0_iREN", {31'h0, iREN}, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            chk("cold_fetch_iREN", {31'h0, iREN}, 32'h1);
            chk("cold_fetch_iaddr", iaddr, 32'h40);
            chk("cold_fetch_ihit", {31'h0, ihit}, 32'h0);
        end
        nextCycle();
        drive(1'b1, 32'h40, 1'b0, 32'h2001000A);
        chk("cold_c4_iREN", {31'h0, iREN}, 32'h1);
        nextCycle();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("cold_c5_ihit", {31'h0, ihit}, 32'h1);
        chk("cold_c5_data", imemload, 32'h2001000A);
        chk("cold_c5_iREN", {31'h0, iREN}, 32'h0);
        chk("cold_c5_misses", miss_count, STATS * 32'd1);

        // Warm hit (cycle 6).
        nextCycle();
        chk("warm_ihit", {31'h0, ihit}, 32'h1);
        chk("warm_data", imemload, 32'h2001000A);
        chk("warm_iREN", {31'h0, iREN}, 32'h0);

        // Conflict: 0x80 shares index 0 with 0x40 (cycles 7..12).
        nextCycle();
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        chk("conf80_miss", {31'h0, ihit}, 32'h0);
        chk("conf80_load0", imemload, 32'h0);
        nextCycle();
        drive(1'b1, 32'h80, 1'b0, 32'h11111111);
        chk("conf80_iaddr", iaddr, 32'h80);
        nextCycle();
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        chk("conf80_hit", {31'h0, ihit}, 32'h1);
        chk("conf80_data", imemload, 32'h11111111);
        nextCycle();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("conf40_miss", {31'h0, ihit}, 32'h0);
        nextCycle();
        drive(1'b1, 32'h40, 1'b0, 32'h2001000A);
        chk("conf40_iaddr", iaddr, 32'h40);
        nextCycle();
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        chk("conf40_hit", {31'h0, ihit}, 32'h1);
        chk("conf40_data", imemload, 32'h2001000A);
        chk("conf_misses", miss_count, STATS * 32'd3);
        chk("conf_hits", hit_count, STATS * 32'd3);

        // Redirect mid-fill: miss on 0x100, then fetch stage moves to 0x200.
        nextCycle();
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        chk("redir_c0_miss", {31'h0, ihit}, 32'h0);
        nextCycle();
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        chk("redir_c1_iaddr", iaddr, 32'h100);
        chk("redir_c1_ihit", {31'h0, ihit}, 32'h0);
        nextCycle();
        drive(1'b1, 32'h200, 1'b0, 32'hAAAA0100);
        chk("redir_c2_iaddr", iaddr, 32'h100);
        chk("redir_c2_ihit", {31'h0, ihit}, 32'h0);
        nextCycle();
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        chk("redir_c3_state", {31'h0, cacheState}, 32'h0);
        chk("redir_c3_miss", {31'h0, ihit}, 32'h0);
        chk("redir_c3_load", imemload, 32'h0);
        chk("redir_c3_iREN", {31'h0, iREN}, 32'h0);
        nextCycle();
        chk("redir_c4_iaddr", iaddr, 32'h200);
        chk("redir_c4_iREN", {31'h0, iREN}, 32'h1);
        chk("redir_misses", miss_count, STATS * 32'd5);
        chk("redir_hits", hit_count, STATS * 32'd4);

        // Reset mid-FETCH.
        nRST = 1'b0;
        #1;
        chk("rstmid_iREN", {31'h0, iREN}, 32'h0);
        chk("rstmid_iaddr", iaddr, 32'h0);
        chk("rstmid_state", {31'h0, cacheState}, 32'h0);
        chk("rstmid_misses", miss_count, 32'h0);
        nextCycle();
        nRST = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        chk("post_rst_miss", {31'h0, ihit}, 32'h0);

        // Drop imemREN during FETCH; the fill must still land.
        nextCycle();
        drive(1'b0, 32'h100, 1'b1, 32'h0);
        chk("drop_iaddr", iaddr, 32'h100);
        nextCycle();
        drive(1'b0, 32'h100, 1'b0, 32'hCAFE0100);
        chk("drop_iREN_held", {31'h0, iREN}, 32'h1);
        nextCycle();
        drive(1'b0, 32'h100, 1'b1, 32'h0);
        chk("idle_noreq_ihit", {31'h0, ihit}, 32'h0);
        chk("idle_noreq_iREN", {31'h0, iREN}, 32'h0);
        chk("idle_noreq_load", imemload, 32'h0);
        nextCycle();
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        chk("drop_later_hit", {31'h0, ihit}, 32'h1);
        chk("drop_later_data", imemload, 32'hCAFE0100);
        chk("drop_misses", miss_count, STATS * 32'd1);
        nextCycle();
        drive(1'b0, 32'h100, 1'b1, 32'h0);
        chk("final_hits", hit_count, STATS * 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
